int_to_float: RTL and testbench
===============================

# int_to_float

Parametrised, pipelined integer-to-IEEE-754 converter with a valid/ready stream interface. It converts signed or unsigned integers, selected per transaction, to a binary floating-point format set by parameters. The default configuration is 32-bit integer to single precision. It replaces the fixed unsigned-32-to-single converter in the math component library and is intended to sit in stream datapaths that need back-pressure.

## Interface
- IN_WIDTH, 32: integer input width; must be ≥ 2.
- EXP_WIDTH, 8: exponent field width.
- MAN_WIDTH, 23: stored mantissa (fraction) width.
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset; one clock, reset asynchronous and active-low.
- in_data  input  IN_WIDTH  integer operand.
- in_signed  input  1  1: in_data is two's complement; 0: unsigned.
- in_valid  input  1  operand present.
- in_ready  output  1  converter accepts an operand this cycle.
- out_data  output  1+EXP_WIDTH+MAN_WIDTH  result, packed {sign, exponent, fraction}.
- out_inexact  output  1  result was rounded (or overflowed).
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts the result this cycle.

## Operation
- Three pipeline stages, each holding a valid bit and data registers.
  - S1: capture the operand. Compute sign = in_signed & in_data[MSB]. Compute magnitude = |in_data| as an IN_WIDTH-bit unsigned value. The signed minimum 2^(IN_WIDTH-1) is representable.
  - S2: compute the leading-one position p of the magnitude and left-normalise it so the leading one sits at the MSB.
  - S3: round and pack. Take the fraction from the bits below the leading one. Form guard, round and sticky from the remaining bits. Round to nearest, ties to even. Biased exponent = p + (2^(EXP_WIDTH-1)−1).
- Rounding carry:
  - If rounding carries out of the fraction, the fraction becomes 0 and the exponent increments by 1.
- Exact cases:
  - If MAN_WIDTH ≥ p, no rounding occurs; the fraction is left-aligned and zero-padded, and inexact = 0.
- Zero:
  - A magnitude of 0 produces all-zero out_data (+0) with inexact = 0.
  - Negative zero is never produced.
- Overflow:
  - If the final biased exponent is ≥ 2^EXP_WIDTH−1, the output is ±infinity: exponent all ones, fraction 0, inexact = 1.
  - This is only reachable for small EXP_WIDTH.
- out_inexact = 1 iff any discarded bit was 1, or overflow occurred.
- Denormal outputs are never produced, since every integer ≥ 1 is ≥ 1.0.

## Timing
- Pipeline advance enable: en = out_ready | ~out_valid.
  - All three stages shift together when en = 1 and hold when en = 0.
  - Bubbles are not collapsed.
- in_ready = en, combinational from out_ready and the S3 valid bit.
- An operand is accepted when in_valid & in_ready.
- Latency: a result appears on out_valid exactly 3 cycles after acceptance when out_ready stays high.
- Throughput: one result per cycle.
- While out_valid = 1 and out_ready = 0:
  - out_data and out_inexact hold stable.
  - in_ready = 0.
  - No operand is lost or duplicated.
- Simultaneous out_ready and in_valid on a full pipeline: the result is retired and the new operand accepted in the same cycle.
- Reset (asynchronous assert, synchronous-safe deassert):
  - All stage valid bits go to 0, so out_valid = 0.
  - out_data = 0 and out_inexact = 0.
  - in_ready = 1 after reset, since out_valid = 0.
- Reset mid-operation discards all in-flight operands; no partial result is emitted.
- in_signed is sampled with in_data at acceptance; changing it later has no effect on in-flight data.

## Test plan
- Unsigned 1, 0, 16777216 with out_ready = 1 → 0x3F800000, 0x00000000, 0x4B800000 three cycles after each; all exact.
- Signed 0xFFFFFFFF (−1) → 0xBF800000. Signed 0x80000000 → 0xCF000000, exact. Unsigned 0xFFFFFFFF → 0x4F800000, inexact = 1 (rounding carry).
- Ties: unsigned 16777217 → 0x4B800000 (tie to even, down); 16777219 → 0x4B800002 (tie to even, up); 16777221 → 0x4B800002; all inexact = 1.
- Back-pressure: stream 10 random operands with in_valid = 1 while out_ready toggles low for 5 cycles mid-stream → all 10 results in order match the reference model; in_ready = 0 while stalled; out_data stable while stalled.
- Reset: assert rst_n low with 3 operands in flight → out_valid = 0 immediately; no result for those operands after release; the next operand completes with 3-cycle latency.
- Parameter sweep IN_WIDTH = 64, EXP_WIDTH = 11, MAN_WIDTH = 52: unsigned 2^53+1 → 0x4340000000000000, inexact. Then IN_WIDTH = 32, EXP_WIDTH = 4, MAN_WIDTH = 3: unsigned 1000 → 0x78 (+inf), inexact = 1.

Source files
------------

// File: rtl/int_to_float.sv
// Three-stage pipelined integer to IEEE-754 converter with valid/ready stream handshake.
// All stages advance together whenever the output slot is free or being drained.
module int_to_float #(
  parameter int IN_WIDTH  = 32,
  parameter int EXP_WIDTH = 8,
  parameter int MAN_WIDTH = 23
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [IN_WIDTH-1:0]          in_data,
  input  logic                         in_signed,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [EXP_WIDTH+MAN_WIDTH:0] out_data,
  output logic                         out_inexact,
  output logic                         out_valid,
  input  logic                         out_ready
);

  localparam int FW      = IN_WIDTH - 1;
  localparam int PW      = $clog2(IN_WIDTH);
  localparam int XW      = EXP_WIDTH + PW + 1;
  localparam int EW      = FW + MAN_WIDTH + 1;
  localparam int BIAS    = (1 << (EXP_WIDTH - 1)) - 1;
  localparam int EXP_MAX = (1 << EXP_WIDTH) - 1;

  logic en;

  logic                s1_valid_q, s1_sign_q;
  logic [IN_WIDTH-1:0] s1_mag_q;
  logic                s1_sign_d;
  logic [IN_WIDTH-1:0] s1_mag_d;

  logic                s2_valid_q, s2_sign_q, s2_zero_q;
  logic [PW-1:0]       s2_pos_q;
  logic [FW-1:0]       s2_frac_q;
  logic [PW-1:0]       s2_pos_d, shamt;
  logic [FW-1:0]       s2_frac_d;
  logic                s2_zero_d;

  logic                         s3_valid_q;
  logic [EXP_WIDTH+MAN_WIDTH:0] out_data_q, out_data_d;
  logic                         out_inexact_q, out_inexact_d;

  assign en          = out_ready | ~s3_valid_q;
  assign in_ready    = en;
  assign out_valid   = s3_valid_q;
  assign out_data    = out_data_q;
  assign out_inexact = out_inexact_q;

  // The two's complement of the signed minimum is itself, which is the correct magnitude.
  always_comb begin
    s1_sign_d = in_signed & in_data[IN_WIDTH-1];
    s1_mag_d  = s1_sign_d ? (~in_data + IN_WIDTH'(1)) : in_data;
  end

  // Leading-one search and normalisation; the leading one itself is implicit and dropped.
  always_comb begin
    s2_pos_d = '0;
    for (int i = 0; i < IN_WIDTH; i++) begin
      if (s1_mag_q[i]) s2_pos_d = PW'(i);
    end
    shamt     = PW'(IN_WIDTH - 1) - s2_pos_d;
    s2_frac_d = FW'(s1_mag_q << shamt);
    s2_zero_d = ~|s1_mag_q;
  end

  logic [EW-1:0]        ext;
  logic [MAN_WIDTH-1:0] frac, frac_rnd;
  logic                 guard, sticky, round_up, carry, ovf;
  logic [XW-1:0]        exp_full;

  // Zero padding below the fraction makes the exact case fall out with guard = sticky = 0.
  always_comb begin
    ext              = {s2_frac_q, {(MAN_WIDTH + 1){1'b0}}};
    frac             = ext[EW-1 -: MAN_WIDTH];
    guard            = ext[FW];
    sticky           = |ext[FW-1:0];
    round_up         = guard & (sticky | frac[0]);
    {carry, frac_rnd} = {1'b0, frac} + {{MAN_WIDTH{1'b0}}, round_up};
    exp_full         = XW'(s2_pos_q) + XW'(BIAS) + XW'(carry);
    ovf              = exp_full >= XW'(EXP_MAX);

    out_data_d    = '0;
    out_inexact_d = 1'b0;
    if (!s2_zero_q) begin
      if (ovf) begin
        out_data_d    = {s2_sign_q, {EXP_WIDTH{1'b1}}, {MAN_WIDTH{1'b0}}};
        out_inexact_d = 1'b1;
      end else begin
        out_data_d    = {s2_sign_q, exp_full[EXP_WIDTH-1:0], frac_rnd};
        out_inexact_d = guard | sticky;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q    <= 1'b0;
      s1_sign_q     <= 1'b0;
      s1_mag_q      <= '0;
      s2_valid_q    <= 1'b0;
      s2_sign_q     <= 1'b0;
      s2_zero_q     <= 1'b0;
      s2_pos_q      <= '0;
      s2_frac_q     <= '0;
      s3_valid_q    <= 1'b0;
      out_data_q    <= '0;
      out_inexact_q <= 1'b0;
    end else if (en) begin
      s1_valid_q <= in_valid;
      s2_valid_q <= s1_valid_q;
      s3_valid_q <= s2_valid_q;
      if (in_valid) begin
        s1_sign_q <= s1_sign_d;
        s1_mag_q  <= s1_mag_d;
      end
      if (s1_valid_q) begin
        s2_sign_q <= s1_sign_q;
        s2_zero_q <= s2_zero_d;
        s2_pos_q  <= s2_pos_d;
        s2_frac_q <= s2_frac_d;
      end
      if (s2_valid_q) begin
        out_data_q    <= out_data_d;
        out_inexact_q <= out_inexact_d;
      end
    end
  end

endmodule

// File: tb/tb_int_to_float.sv
// Scoreboard bench for int_to_float: default, double-precision and tiny-exponent configurations.
module tb_int_to_float;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  bit   lat_chk = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] in_data;
  logic        in_signed, in_valid, in_ready;
  logic [31:0] out_data;
  logic        out_inexact, out_valid, out_ready;

  logic [63:0] d64_in_data, d64_out_data;
  logic        d64_in_signed, d64_in_valid, d64_in_ready, d64_out_inexact, d64_out_valid;
  logic [31:0] d4_in_data;
  logic [7:0]  d4_out_data;
  logic        d4_in_signed, d4_in_valid, d4_in_ready, d4_out_inexact, d4_out_valid;

  int_to_float u_dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_signed(in_signed), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_inexact(out_inexact), .out_valid(out_valid),
    .out_ready(out_ready));

  int_to_float #(.IN_WIDTH(64), .EXP_WIDTH(11), .MAN_WIDTH(52)) u_d64 (
    .clk(clk), .rst_n(rst_n), .in_data(d64_in_data), .in_signed(d64_in_signed),
    .in_valid(d64_in_valid), .in_ready(d64_in_ready), .out_data(d64_out_data),
    .out_inexact(d64_out_inexact), .out_valid(d64_out_valid), .out_ready(1'b1));

  int_to_float #(.IN_WIDTH(32), .EXP_WIDTH(4), .MAN_WIDTH(3)) u_d4 (
    .clk(clk), .rst_n(rst_n), .in_data(d4_in_data), .in_signed(d4_in_signed),
    .in_valid(d4_in_valid), .in_ready(d4_in_ready), .out_data(d4_out_data),
    .out_inexact(d4_out_inexact), .out_valid(d4_out_valid), .out_ready(1'b1));

  typedef struct {
    logic [63:0] data;
    logic        inx;
    int          acc;
  } exp_t;

  exp_t q0[$];
  exp_t q64[$];
  exp_t q4[$];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Reference: integer division / remainder rounding, bit {inexact, packed result}.
  function automatic logic [64:0] model(input logic [63:0] v_in, input bit s, input int iw,
                                        input int ew, input int mw);
    logic [63:0] mask, v, mag, q, rem, half, res;
    bit sg, inx;
    int p, sh, e;
    mask = (iw == 64) ? '1 : ((64'd1 << iw) - 64'd1);
    v    = v_in & mask;
    sg   = s && v[iw-1];
    mag  = sg ? ((~v + 64'd1) & mask) : v;
    if (mag == 64'd0) return 65'd0;
    p = 0;
    for (int i = 0; i < 64; i++) if (mag[i]) p = i;
    inx = 1'b0;
    if (p <= mw) begin
      q = mag << (mw - p);
    end else begin
      sh   = p - mw;
      q    = mag >> sh;
      rem  = mag & ((64'd1 << sh) - 64'd1);
      half = 64'd1 << (sh - 1);
      inx  = (rem != 64'd0);
      if (rem > half || (rem == half && q[0])) q = q + 64'd1;
      if (q == (64'd1 << (mw + 1))) begin
        q = q >> 1;
        p = p + 1;
      end
    end
    e = p + (1 << (ew - 1)) - 1;
    if (e >= (1 << ew) - 1) begin
      res = (64'(sg) << (ew + mw)) | (64'((1 << ew) - 1) << mw);
      return {1'b1, res};
    end
    res = (64'(sg) << (ew + mw)) | (64'(e) << mw) | (q & ((64'd1 << mw) - 64'd1));
    return {inx, res};
  endfunction

  task automatic send(input logic [31:0] val, input bit s, input bit use_exp,
                      input logic [31:0] ed, input bit ei);
    logic [64:0] m;
    exp_t e;
    int n;
    bit done;
    in_data = val;
    in_signed = s;
    in_valid = 1'b1;
    if (use_exp) begin
      e.data = {32'd0, ed};
      e.inx  = ei;
    end else begin
      m = model({32'd0, val}, s, 32, 8, 23);
      e.data = m[63:0];
      e.inx  = m[64];
    end
    n = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        e.acc = cyc;
        q0.push_back(e);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
      n++;
      if (!done && n > 200) begin
        fail_now("accept_timeout");
        done = 1'b1;
      end
    end
  endtask

  task automatic send_alt(input bit wide, input logic [63:0] val, input bit s, input bit use_exp,
                          input logic [63:0] ed, input bit ei);
    logic [64:0] m;
    exp_t e;
    if (use_exp) begin
      e.data = ed;
      e.inx  = ei;
    end else begin
      m = wide ? model(val, s, 64, 11, 52) : model(val, s, 32, 4, 3);
      e.data = m[63:0];
      e.inx  = m[64];
    end
    if (wide) begin
      d64_in_data = val; d64_in_signed = s; d64_in_valid = 1'b1;
    end else begin
      d4_in_data = val[31:0]; d4_in_signed = s; d4_in_valid = 1'b1;
    end
    @(negedge clk);
    e.acc = cyc;
    if (wide ? d64_in_ready : d4_in_ready) begin
      if (wide) q64.push_back(e);
      else q4.push_back(e);
    end else fail_now("alt_in_ready_low");
    @(posedge clk);
    #1;
    d64_in_valid = 1'b0;
    d4_in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q0.size() != 0 || q64.size() != 0 || q4.size() != 0) begin
      @(posedge clk);
      n++;
      if (n > 300) begin
        fail_now("drain_timeout");
        q0.delete(); q64.delete(); q4.delete();
      end
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Main-DUT monitor: retire against the scoreboard and police stall behaviour.
  initial begin
    bit prev_stall;
    logic [32:0] prev;
    exp_t e;
    prev_stall = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
        continue;
      end
      if (out_valid && !out_ready) begin
        chk("stall_in_ready", 64'(in_ready), 64'd0);
        if (prev_stall) chk("stall_hold", 64'({out_inexact, out_data}), 64'(prev));
      end
      prev_stall = out_valid && !out_ready;
      prev = {out_inexact, out_data};
      if (out_valid && out_ready) begin
        if (q0.size() == 0) begin
          fail_now("unexpected_output");
        end else begin
          e = q0.pop_front();
          chk("data", 64'(out_data), e.data);
          chk("inexact", 64'(out_inexact), 64'(e.inx));
          if (lat_chk) chk("latency", 64'(cyc - e.acc), 64'd3);
        end
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && d64_out_valid) begin
        if (q64.size() == 0) fail_now("d64_unexpected_output");
        else begin
          e = q64.pop_front();
          chk("d64_data", d64_out_data, e.data);
          chk("d64_inexact", 64'(d64_out_inexact), 64'(e.inx));
          chk("d64_latency", 64'(cyc - e.acc), 64'd3);
        end
      end
      if (rst_n && d4_out_valid) begin
        if (q4.size() == 0) fail_now("d4_unexpected_output");
        else begin
          e = q4.pop_front();
          chk("d4_data", 64'(d4_out_data), e.data);
          chk("d4_inexact", 64'(d4_out_inexact), 64'(e.inx));
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  logic [31:0] dir_val [9];
  bit          dir_sgn [9];
  logic [31:0] dir_exp [9];
  bit          dir_inx [9];

  initial begin
    bit rnd_done;
    in_data = '0; in_signed = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    d64_in_data = '0; d64_in_signed = 1'b0; d64_in_valid = 1'b0;
    d4_in_data = '0; d4_in_signed = 1'b0; d4_in_valid = 1'b0;

    dir_val = '{32'd1, 32'd0, 32'd16777216, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF,
                32'd16777217, 32'd16777219, 32'd16777221};
    dir_sgn = '{0, 0, 0, 1, 1, 0, 0, 0, 0};
    dir_exp = '{32'h3F800000, 32'h00000000, 32'h4B800000, 32'hBF800000, 32'hCF000000,
                32'h4F800000, 32'h4B800000, 32'h4B800002, 32'h4B800002};
    dir_inx = '{0, 0, 0, 0, 0, 1, 1, 1, 1};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_out_data", 64'(out_data), 64'd0);
    chk("reset_out_inexact", 64'(out_inexact), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    lat_chk = 1'b1;
    for (int i = 0; i < 9; i++) send(dir_val[i], dir_sgn[i], 1'b1, dir_exp[i], dir_inx[i]);
    in_valid = 1'b0;
    drain();

    send_alt(1'b1, 64'h0020000000000001, 1'b0, 1'b1, 64'h4340000000000000, 1'b1);
    send_alt(1'b0, 64'd1000, 1'b0, 1'b1, 64'h78, 1'b1);
    for (int i = 0; i < 12; i++) begin
      send_alt(1'b1, {$urandom, $urandom} >> $urandom_range(0, 63), 1'($urandom_range(0, 1)),
               1'b0, 64'd0, 1'b0);
      send_alt(1'b0, 64'($urandom >> $urandom_range(0, 31)), 1'($urandom_range(0, 1)),
               1'b0, 64'd0, 1'b0);
    end
    drain();

    lat_chk = 1'b0;
    fork
      begin
        for (int i = 0; i < 10; i++) send($urandom, 1'($urandom_range(0, 1)), 1'b0, 32'd0, 1'b0);
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    in_valid = 1'b0;
    drain();

    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 30; i++)
          send($urandom >> $urandom_range(0, 31), 1'($urandom_range(0, 1)), 1'b0, 32'd0, 1'b0);
        in_valid = 1'b0;
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          out_ready = 1'($urandom_range(0, 1));
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();

    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send($urandom, 1'b0, 1'b0, 32'd0, 1'b0);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midreset_out_valid", 64'(out_valid), 64'd0);
    chk("midreset_out_data", 64'(out_data), 64'd0);
    chk("midreset_out_inexact", 64'(out_inexact), 64'd0);
    chk("midreset_in_ready", 64'(in_ready), 64'd1);
    q0.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    lat_chk = 1'b1;
    send(32'hFFFFFFFE, 1'b1, 1'b1, 32'hC0000000, 1'b0);
    in_valid = 1'b0;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
